// File: rtl/gb_dma_pkg.sv
// Shared constants and beat type for the GBC HDMA/GDMA data path.
package gb_dma_pkg;

    localparam logic [15:0] VRAM_LO   = 16'h8000;
    localparam logic [15:0] VRAM_HI   = 16'h9FFF;
    localparam logic [15:0] ECHO_LO   = 16'hE000;
    localparam logic [15:0] ECHO_MASK = 16'hBFFF;
    localparam logic [7:0]  DMA_FILL  = 8'hFF;

    typedef struct packed {
        logic [15:0] src;
        logic [12:0] tgt;
        logic        is_vram;
    } dma_beat_t;

endpackage

// File: rtl/hdma_xfer_if.sv
// Bus bundle between the HDMA register block, memory arbiter, VRAM and the mover.
interface hdma_xfer_if;
    logic        hdma_rd;
    logic [15:0] hdma_source_addr;
    logic [15:0] hdma_target_addr;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din;
    logic        vram_we;
    logic [12:0] vram_addr;
    logic [7:0]  vram_dout;
    logic        cpu_stall;
    logic [11:0] byte_cnt;

    modport master (
        output hdma_rd, hdma_source_addr, hdma_target_addr, mem_din,
        input  mem_rd, mem_addr, vram_we, vram_addr, vram_dout, cpu_stall, byte_cnt
    );

    modport slave (
        input  hdma_rd, hdma_source_addr, hdma_target_addr, mem_din,
        output mem_rd, mem_addr, vram_we, vram_addr, vram_dout, cpu_stall, byte_cnt
    );
endinterface

// File: rtl/hdma_src_map.sv
// Classifies a DMA source address and folds the echo region back onto cart RAM.
module hdma_src_map
    import gb_dma_pkg::*;
#(
    parameter bit SRC_ECHO_REMAP = 1'b1
) (
    input  logic [15:0] src,
    output logic [15:0] mapped,
    output logic        is_vram
);

    logic in_echo;

    assign is_vram = (src >= VRAM_LO) && (src <= VRAM_HI);
    assign in_echo = SRC_ECHO_REMAP && (src >= ECHO_LO);
    assign mapped  = in_echo ? (src & ECHO_MASK) : src;

endmodule

// File: rtl/hdma_xfer.sv
// HDMA/GDMA byte mover: accept -> S1 bus read -> S2 VRAM write, one byte per stage.
module hdma_xfer
    import gb_dma_pkg::*;
#(
    parameter bit SRC_ECHO_REMAP = 1'b1
) (
    input  logic      clk,
    input  logic      reset,
    hdma_xfer_if.slave bus
);

    logic        prev_rd_reg;
    logic [15:0] last_src_reg;
    logic        accept;

    logic        s1_valid_reg;
    dma_beat_t   s1_beat_reg;
    dma_beat_t   s1_beat_next;

    logic        s2_valid_reg;
    logic [12:0] vram_addr_reg;
    logic [7:0]  vram_dout_reg;
    logic [11:0] byte_cnt_reg;

    logic [15:0] src_mapped;
    logic        src_is_vram;
    logic        unused_tgt_hi;

    assign unused_tgt_hi = ^bus.hdma_target_addr[15:13];

    hdma_src_map #(
        .SRC_ECHO_REMAP (SRC_ECHO_REMAP)
    ) u_src_map (
        .src     (bus.hdma_source_addr),
        .mapped  (src_mapped),
        .is_vram (src_is_vram)
    );

    // A held request only re-triggers when the controller advances the source.
    assign accept = bus.hdma_rd &&
                    (!prev_rd_reg || (bus.hdma_source_addr != last_src_reg));

    always_comb begin
        s1_beat_next         = s1_beat_reg;
        if (accept) begin
            s1_beat_next.src     = src_mapped;
            s1_beat_next.tgt     = bus.hdma_target_addr[12:0];
            s1_beat_next.is_vram = src_is_vram;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_rd_reg  <= 1'b0;
            last_src_reg <= 16'h0000;
            s1_valid_reg <= 1'b0;
            s1_beat_reg  <= '0;
        end else begin
            prev_rd_reg  <= bus.hdma_rd;
            s1_valid_reg <= accept;
            s1_beat_reg  <= s1_beat_next;
            if (accept) begin
                last_src_reg <= bus.hdma_source_addr;
            end
        end
    end

    // mem_din is valid in the S1 cycle, so S2 captures it on the same edge S1 retires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_reg  <= 1'b0;
            vram_addr_reg <= 13'h0000;
            vram_dout_reg <= 8'h00;
            byte_cnt_reg  <= 12'h000;
        end else begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                vram_addr_reg <= s1_beat_reg.tgt;
                vram_dout_reg <= s1_beat_reg.is_vram ? DMA_FILL : bus.mem_din;
            end
            if (s2_valid_reg) begin
                byte_cnt_reg <= byte_cnt_reg + 12'd1;
            end
        end
    end

    assign bus.mem_rd    = s1_valid_reg && !s1_beat_reg.is_vram;
    assign bus.mem_addr  = s1_beat_reg.src;
    assign bus.vram_we   = s2_valid_reg;
    assign bus.vram_addr = vram_addr_reg;
    assign bus.vram_dout = vram_dout_reg;
    assign bus.byte_cnt  = byte_cnt_reg;
    assign bus.cpu_stall = bus.hdma_rd | s1_valid_reg | s2_valid_reg;

endmodule

// File: tb/tb_hdma_xfer.sv
// Directed bench for hdma_xfer: inputs change 1ns after posedge, outputs sampled at negedge.
module tb_hdma_xfer;
    logic clk = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_pass  = 0;
    int   exp_cnt = 0;

    hdma_xfer_if bus ();

    hdma_xfer #(.SRC_ECHO_REMAP(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
            $display("check %-14s got %0h expected %0h ok", tag, got, exp);
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic req(input logic rd, input logic [15:0] src, input logic [15:0] tgt);
        bus.hdma_rd          = rd;
        bus.hdma_source_addr = src;
        bus.hdma_target_addr = tgt;
    endtask

    initial begin
        reset = 1'b1;
        req(1'b0, 16'h0000, 16'h0000);
        bus.mem_din = 8'h00;
        tick(); tick();
        mid();
        chk("rst_mem_rd",  {31'd0, bus.mem_rd},    32'd0);
        chk("rst_vram_we", {31'd0, bus.vram_we},   32'd0);
        chk("rst_stall",   {31'd0, bus.cpu_stall}, 32'd0);
        chk("rst_cnt",     {20'd0, bus.byte_cnt},  32'd0);
        chk("rst_addr",    {16'd0, bus.mem_addr},  32'd0);
        chk("rst_vaddr",   {19'd0, bus.vram_addr}, 32'd0);
        chk("rst_dout",    {24'd0, bus.vram_dout}, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // basic two-byte transfer
        req(1'b1, 16'h2040, 16'h8200);
        mid();
        chk("b_stall0", {31'd0, bus.cpu_stall}, 32'd1);
        chk("b_rd0",    {31'd0, bus.mem_rd},    32'd0);
        tick();
        bus.mem_din = 8'h11;
        mid();
        chk("b_rd1",    {31'd0, bus.mem_rd},   32'd1);
        chk("b_addr1",  {16'd0, bus.mem_addr}, 32'h2040);
        tick();
        req(1'b1, 16'h2041, 16'h8201);
        mid();
        chk("b_we2",    {31'd0, bus.vram_we},   32'd1);
        chk("b_vaddr2", {19'd0, bus.vram_addr}, 32'h0200);
        chk("b_dout2",  {24'd0, bus.vram_dout}, 32'h11);
        chk("b_rd2",    {31'd0, bus.mem_rd},    32'd0);
        tick();
        bus.mem_din = 8'h22;
        mid();
        chk("b_rd3",    {31'd0, bus.mem_rd},   32'd1);
        chk("b_addr3",  {16'd0, bus.mem_addr}, 32'h2041);
        chk("b_we3",    {31'd0, bus.vram_we},  32'd0);
        chk("b_cnt3",   {20'd0, bus.byte_cnt}, 32'd1);
        tick();
        req(1'b0, 16'h2041, 16'h8201);
        mid();
        chk("b_we4",    {31'd0, bus.vram_we},   32'd1);
        chk("b_vaddr4", {19'd0, bus.vram_addr}, 32'h0201);
        chk("b_dout4",  {24'd0, bus.vram_dout}, 32'h22);
        chk("b_stall4", {31'd0, bus.cpu_stall}, 32'd1);
        tick();
        mid();
        exp_cnt = 2;
        chk("b_cnt5",   {20'd0, bus.byte_cnt},  exp_cnt);
        chk("b_stall5", {31'd0, bus.cpu_stall}, 32'd0);
        chk("b_we5",    {31'd0, bus.vram_we},   32'd0);
        tick();

        // echo remap
        req(1'b1, 16'hE123, 16'h8300);
        tick();
        bus.mem_din = 8'h5A;
        mid();
        chk("e_rd",    {31'd0, bus.mem_rd},   32'd1);
        chk("e_addr",  {16'd0, bus.mem_addr}, 32'hA123);
        tick();
        req(1'b0, 16'hE123, 16'h8300);
        mid();
        chk("e_we",    {31'd0, bus.vram_we},   32'd1);
        chk("e_dout",  {24'd0, bus.vram_dout}, 32'h5A);
        chk("e_vaddr", {19'd0, bus.vram_addr}, 32'h0300);
        tick(); tick();
        exp_cnt++;

        // VRAM source: no bus read, fill data
        req(1'b1, 16'h8800, 16'h8400);
        tick();
        bus.mem_din = 8'h33;
        mid();
        chk("v_rd",    {31'd0, bus.mem_rd},    32'd0);
        chk("v_stall", {31'd0, bus.cpu_stall}, 32'd1);
        tick();
        req(1'b0, 16'h8800, 16'h8400);
        mid();
        chk("v_we",    {31'd0, bus.vram_we},   32'd1);
        chk("v_dout",  {24'd0, bus.vram_dout}, 32'hFF);
        tick(); tick();
        exp_cnt++;

        // drain after the request falls
        req(1'b1, 16'h4000, 16'h0010);
        tick();
        req(1'b0, 16'h4000, 16'h0010);
        bus.mem_din = 8'h77;
        mid();
        chk("d_rd",     {31'd0, bus.mem_rd},    32'd1);
        chk("d_stall1", {31'd0, bus.cpu_stall}, 32'd1);
        tick();
        mid();
        chk("d_we",     {31'd0, bus.vram_we},   32'd1);
        chk("d_dout",   {24'd0, bus.vram_dout}, 32'h77);
        chk("d_vaddr",  {19'd0, bus.vram_addr}, 32'h0010);
        tick();
        mid();
        exp_cnt++;
        chk("d_stall3", {31'd0, bus.cpu_stall}, 32'd0);
        chk("d_cnt",    {20'd0, bus.byte_cnt},  exp_cnt);
        tick();

        // re-accept the same source after a 1-0-1 request
        req(1'b1, 16'h3000, 16'h8500);
        tick();
        req(1'b0, 16'h3000, 16'h8500);
        bus.mem_din = 8'h01;
        tick();
        req(1'b1, 16'h3000, 16'h8501);
        mid();
        chk("r_dout1",  {24'd0, bus.vram_dout}, 32'h01);
        tick();
        req(1'b0, 16'h3000, 16'h8501);
        bus.mem_din = 8'h02;
        mid();
        chk("r_rd2",    {31'd0, bus.mem_rd},   32'd1);
        chk("r_addr2",  {16'd0, bus.mem_addr}, 32'h3000);
        tick();
        mid();
        chk("r_we2",    {31'd0, bus.vram_we},   32'd1);
        chk("r_dout2",  {24'd0, bus.vram_dout}, 32'h02);
        chk("r_vaddr2", {19'd0, bus.vram_addr}, 32'h0501);
        tick();
        mid();
        exp_cnt += 2;
        chk("r_cnt",    {20'd0, bus.byte_cnt},  exp_cnt);
        tick();

        // asynchronous reset while S1 holds a byte
        req(1'b1, 16'h5000, 16'h8600);
        tick();
        req(1'b0, 16'h5000, 16'h8600);
        mid();
        chk("a_rd_pre", {31'd0, bus.mem_rd}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("a_rd",    {31'd0, bus.mem_rd},    32'd0);
        chk("a_we",    {31'd0, bus.vram_we},   32'd0);
        chk("a_cnt",   {20'd0, bus.byte_cnt},  32'd0);
        chk("a_stall", {31'd0, bus.cpu_stall}, 32'd0);
        chk("a_addr",  {16'd0, bus.mem_addr},  32'd0);
        tick();
        reset = 1'b0;
        mid();
        chk("a_we1", {31'd0, bus.vram_we}, 32'd0);
        tick();
        mid();
        chk("a_we2",  {31'd0, bus.vram_we},  32'd0);
        chk("a_cnt2", {20'd0, bus.byte_cnt}, 32'd0);
        tick();

        // counter wrap: 4096 bytes at controller pacing
        for (int i = 0; i < 4096; i++) begin
            req(1'b1, 16'h1000 + 16'(i), 16'(i));
            tick();
            bus.mem_din = 8'(i);
            tick();
            if (i == 4094) begin
                mid();
                chk("w_cnt_pre", {20'd0, bus.byte_cnt}, 32'hFFE);
            end
        end
        req(1'b0, 16'h0000, 16'h0000);
        mid();
        chk("w_we_last",   {31'd0, bus.vram_we},   32'd1);
        chk("w_dout_last", {24'd0, bus.vram_dout}, 32'hFF);
        tick(); tick(); tick();
        mid();
        chk("w_cnt_wrap", {20'd0, bus.byte_cnt},  32'd0);
        chk("w_stall",    {31'd0, bus.cpu_stall}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
